// File: rtl/ones_mod3_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ones_mod3_arbiter
//  Description : Round-robin arbiter in front of one shared serial
//                ones-count-mod-3 engine. The granted word is shifted
//                LSB-first through a three-state residue FSM. The result
//                (residue, div3) is reported with the requester id.
//  Option      : ONES_MOD3_EARLY_EXIT_EN - leave SHIFT as soon as the
//                remaining shift register is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module ones_mod3_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] data,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic                  done,
   output logic [IDW-1:0]        done_id,
   output logic [1:0]            residue,
   output logic                  div3
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, REPORT = 2'd2} state_t;
   typedef enum logic [1:0] {R0 = 2'd0, R1 = 2'd1, R2 = 2'd2} res_t;

   state_t              state_q, state_d;
   res_t                res_q, res_d;
   logic [IDW-1:0]      ptr_q, ptr_d;
   logic [IDW-1:0]      win_q, win_d;
   logic [WIDTH-1:0]    sh_q, sh_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [IDW-1:0]      done_id_q, done_id_d;
   logic [1:0]          residue_q, residue_d;
   logic                div3_q, div3_d;

   logic [IDW-1:0]      w_pick;
   logic [WIDTH-1:0]    sh_next;
   res_t                res_adv;
   logic                last_bit;

   // First requester at or after the pointer, wrapping modulo NREQ.
   // Iterating downward lets the closest candidate overwrite farther ones.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDW-1:0]  p);
      int idx;
      rr_pick = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(p) + k) % NREQ;
         if (r[idx]) rr_pick = IDW'(idx);
      end
   endfunction

   // Residue FSM transition: advance one state on a '1', hold on a '0'.
   function automatic res_t res_step(input res_t r, input logic b);
      res_step = r;
      if (b) begin
         case (r)
            R0:      res_step = R1;
            R1:      res_step = R2;
            default: res_step = R0;
         endcase
      end
   endfunction

   // Next-state, datapath and output computation for the controller.
   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      ptr_d     = ptr_q;
      win_d     = win_q;
      sh_d      = sh_q;
      cnt_d     = cnt_q;
      gnt_d     = '0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      residue_d = residue_q;
      div3_d    = div3_q;

      w_pick   = rr_pick(req, ptr_q);
      sh_next  = {1'b0, sh_q[WIDTH-1:1]};
      res_adv  = res_step(res_q, sh_q[0]);
`ifdef ONES_MOD3_EARLY_EXIT_EN
      // No ones left to count once the remaining register is empty.
      last_bit = (cnt_q == CW'(WIDTH - 1)) || (sh_next == '0);
`else
      last_bit = (cnt_q == CW'(WIDTH - 1));
`endif

      case (state_q)
         IDLE: begin
            if (|req) begin
               win_d         = w_pick;
               sh_d          = data[int'(w_pick)*WIDTH +: WIDTH];
               cnt_d         = '0;
               res_d         = R0;
               gnt_d[w_pick] = 1'b1;
               busy_d        = 1'b1;
               ptr_d         = (int'(w_pick) == NREQ - 1) ? '0 : w_pick + IDW'(1);
               state_d       = SHIFT;
            end
         end
         SHIFT: begin
            sh_d  = sh_next;
            cnt_d = cnt_q + CW'(1);
            res_d = res_adv;
            if (last_bit) begin
               // Result registered on the edge that enters REPORT, so it
               // already includes the final bit.
               state_d   = REPORT;
               done_d    = 1'b1;
               done_id_d = win_q;
               residue_d = res_adv;
               div3_d    = (res_adv == R0);
            end
         end
         REPORT: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         res_q     <= R0;
         ptr_q     <= '0;
         win_q     <= '0;
         sh_q      <= '0;
         cnt_q     <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         residue_q <= 2'd0;
         div3_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         res_q     <= res_d;
         ptr_q     <= ptr_d;
         win_q     <= win_d;
         sh_q      <= sh_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         residue_q <= residue_d;
         div3_q    <= div3_d;
      end
   end

   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign done_id = done_id_q;
   assign residue = residue_q;
   assign div3    = div3_q;

endmodule
`default_nettype wire

// File: tb/tb_ones_mod3_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ones_mod3_arbiter
//  Description : Directed self-checking bench for ones_mod3_arbiter
//                (default or ONES_MOD3_EARLY_EXIT_EN build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ones_mod3_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;
`ifdef ONES_MOD3_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*WIDTH-1:0] data = '0;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic                  done;
   logic [IDW-1:0]        done_id;
   logic [1:0]            residue;
   logic                  div3;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   ones_mod3_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .data    (data),
      .gnt     (gnt),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .residue (residue),
      .div3    (div3)
   );

   always #5 clk = ~clk;

   // Advance one edge and sample 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Request one word from one requester and check grant, latency and result.
   task automatic run_word(input int id, input logic [7:0] w, input logic [1:0] er,
                           input logic ed, input int elat, input string nm);
      int n;
      data[id*WIDTH +: WIDTH] = w;
      req = 4'b0001 << id;
      n = 0;
      while (gnt === 4'b0000 && n < 20) begin tick(); n++; end
      n_cmp++;
      if (gnt !== (4'b0001 << id)) begin
         n_bad++;
         $display("FAIL %s gnt: got %b want %b", nm, gnt, 4'b0001 << id);
      end
      req = '0;
      n = 0;
      do begin
         tick(); n++;
         if (n == 1) begin
            n_cmp++;
            if (gnt !== 4'b0000) begin
               n_bad++;
               $display("FAIL %s gnt_one_cycle: got %b want 0000", nm, gnt);
            end
         end
      end while (done !== 1'b1 && n < 30);
      n_cmp++;
      if (n != elat) begin
         n_bad++;
         $display("FAIL %s latency: got %0d want %0d", nm, n, elat);
      end
      n_cmp++;
      if ({done_id, residue, div3} !== {2'(id), er, ed}) begin
         n_bad++;
         $display("FAIL %s result: got id=%0d res=%0d div3=%0d want id=%0d res=%0d div3=%0d",
                  nm, done_id, residue, div3, id, er, ed);
      end
      tick();
      n_cmp++;
      if ({done, busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL %s end: got done=%b busy=%b want 0 0", nm, done, busy);
      end
   endtask

   task automatic test_reset();
      tick(); tick();
      n_cmp++;
      if ({gnt, busy, done, done_id, residue, div3} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: got gnt=%b busy=%b done=%b id=%0d res=%0d div3=%b want all 0",
                  gnt, busy, done, done_id, residue, div3);
      end
      // Start a word, then reset mid-run and confirm nothing restarts.
      rst = 1'b1;
      data[7:0] = 8'hFF;
      req = 4'b0001;
      tick(); tick(); tick();
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      req = '0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++;
         if ({gnt, busy, done, done_id, residue, div3} !== '0) begin
            n_bad++;
            $display("FAIL reset_idle[%0d]: got gnt=%b busy=%b done=%b id=%0d res=%0d div3=%b want all 0",
                     i, gnt, busy, done, done_id, residue, div3);
         end
      end
   endtask

   task automatic test_single();
      run_word(0, 8'hB7, 2'd0, 1'b1, 8, "single_B7");
   endtask

   task automatic test_residue();
      run_word(2, 8'h01, 2'd1, 1'b0, EE ? 1 : 8, "word_01");
      run_word(1, 8'h00, 2'd0, 1'b1, EE ? 1 : 8, "word_00");
      run_word(3, 8'h05, 2'd2, 1'b0, EE ? 3 : 8, "word_05");
      run_word(2, 8'hFF, 2'd2, 1'b0, 8, "word_FF");
   endtask

   task automatic test_reset_mid_shift();
      int n;
      data[23:16] = 8'hB7;
      req = 4'b0100;
      n = 0;
      while (gnt === 4'b0000 && n < 20) begin tick(); n++; end
      req = '0;
      tick(); tick(); tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({gnt, busy, done, done_id, residue, div3} !== '0) begin
         n_bad++;
         $display("FAIL mid_reset_clear: got busy=%b done=%b id=%0d res=%0d div3=%b want all 0",
                  busy, done, done_id, residue, div3);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 1) rst = 1'b1;
         n_cmp++;
         if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_no_done[%0d]: got %b want 0", i, done);
         end
      end
      // Pointer must be back at 0: with req=1010 the winner is requester 1.
      data[15:8]  = 8'h01;
      data[31:24] = 8'hFF;
      req = 4'b1010;
      n = 0;
      while (gnt === 4'b0000 && n < 20) begin tick(); n++; end
      n_cmp++;
      if (gnt !== 4'b0010) begin
         n_bad++;
         $display("FAIL mid_reset_first_gnt: got %b want 0010", gnt);
      end
      req = '0;
      n = 0;
      while (done !== 1'b1 && n < 30) begin tick(); n++; end
      n_cmp++;
      if ({done, done_id, residue} !== {1'b1, 2'd1, 2'd1}) begin
         n_bad++;
         $display("FAIL mid_reset_result: got done=%b id=%0d res=%0d want 1 1 1", done, done_id, residue);
      end
      tick(); tick();
   endtask

   task automatic test_round_robin();
      logic [7:0] w [4];
      logic [1:0] r [4];
      int         lat [4];
      int         n, last_g, k;
      w = '{8'hB7, 8'hFF, 8'h01, 8'h00};
      r = '{2'd0, 2'd2, 2'd1, 2'd0};
      lat = '{8, 8, EE ? 1 : 8, EE ? 1 : 8};
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) data[i*WIDTH +: WIDTH] = w[i];
      req = 4'b1111;
      last_g = 0;
      for (int g = 0; g < 5; g++) begin
         k = g % 4;
         n = 0;
         while (gnt === 4'b0000 && n < 20) begin tick(); n++; end
         n_cmp++;
         if (gnt !== (4'b0001 << k)) begin
            n_bad++;
            $display("FAIL rr_gnt[%0d]: got %b want %b", g, gnt, 4'b0001 << k);
         end
         if (g > 0) begin
            n_cmp++;
            if (cyc - last_g != lat[(g - 1) % 4] + 2) begin
               n_bad++;
               $display("FAIL rr_gap[%0d]: got %0d want %0d", g, cyc - last_g, lat[(g - 1) % 4] + 2);
            end
         end
         last_g = cyc;
         n = 0;
         do begin tick(); n++; end while (done !== 1'b1 && n < 30);
         n_cmp++;
         if (n != lat[k] || done_id !== 2'(k) || residue !== r[k]) begin
            n_bad++;
            $display("FAIL rr_done[%0d]: got lat=%0d id=%0d res=%0d want lat=%0d id=%0d res=%0d",
                     g, n, done_id, residue, lat[k], k, r[k]);
         end
      end
      req = '0;
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_residue();
      test_reset_mid_shift();
      test_round_robin();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
